// File: rtl/bnn_pkg.sv
// Shared constants, phase encodings and flat-vector index helpers for the binary MNIST network.
package bnn_pkg;

  localparam logic [2:0] s_IDLE    = 3'b000;
  localparam logic [2:0] s_LOAD    = 3'b001;
  localparam logic [2:0] s_LAYER_1 = 3'b010;
  localparam logic [2:0] s_LAYER_2 = 3'b011;
  localparam logic [2:0] s_LAYER_3 = 3'b100;

  localparam int IMG_DIM    = 28;
  localparam int POOL_DIM   = 14;
  localparam int L1_FILTERS = 8;
  localparam int KSIZE      = 3;

  localparam int KTAPS = KSIZE * KSIZE;
  localparam int PIX_W = IMG_DIM * IMG_DIM;
  localparam int W1_W  = KTAPS * L1_FILTERS;
  localparam int FM1_W = POOL_DIM * POOL_DIM * L1_FILTERS;

  typedef enum logic [1:0] {
    L1_IDLE = 2'd0,
    L1_RUN  = 2'd1,
    L1_DONE = 2'd2
  } l1_fsm_t;

  function automatic int pix_idx(input int r, input int c);
    return r * IMG_DIM + c;
  endfunction

  function automatic int w1_idx(input int kr, input int kc, input int f);
    return kr * KSIZE * L1_FILTERS + kc * L1_FILTERS + f;
  endfunction

  function automatic int fm1_idx(input int pr, input int pc, input int f);
    return (pr * POOL_DIM + pc) * L1_FILTERS + f;
  endfunction

endpackage

// File: rtl/bconv3x3_pe.sv
// One binary 3x3 convolution tap set: XNOR window against kernel, popcount, threshold.
// Purely combinational; one instance per layer-1 filter.
module bconv3x3_pe
  import bnn_pkg::*;
#(
  parameter int THRESH = 5
) (
  input  logic [KTAPS-1:0] window,
  input  logic [KTAPS-1:0] kernel,
  output logic             act
);

  localparam logic [3:0] THR = 4'(THRESH);

  logic [KTAPS-1:0] match;
  logic [3:0]       count;

  assign match = ~(window ^ kernel);

  always_comb begin
    count = '0;
    for (int i = 0; i < KTAPS; i++) begin
      count = count + {3'b000, match[i]};
    end
  end

  assign act = (count >= THR);

endmodule

// File: rtl/bnn_layer1_conv.sv
// Layer-1 engine: 8 binary 3x3 same-padded convolutions, threshold and 2x2 max-pool into a 14x14x8 map.
// One conv position per cycle (784 cycles per image); no backpressure, inputs must hold during the pass.
module bnn_layer1_conv
  import bnn_pkg::*;
#(
  parameter int THRESH = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       state,
  input  logic [PIX_W-1:0] pixels,
  input  logic [W1_W-1:0]  weights1,
  output logic [FM1_W-1:0] fmap1,
  output logic             layer1_done
);

  localparam logic [3:0] LAST_POS = 4'(POOL_DIM - 1);

  l1_fsm_t                fsm;
  logic [3:0]             pr;
  logic [3:0]             pc;
  logic [1:0]             q;
  logic [L1_FILTERS-1:0]  acc;
  logic [L1_FILTERS-1:0]  act;
  logic [KTAPS-1:0]       window;
  logic [KTAPS-1:0]       kern [L1_FILTERS];

  // Gather the 3x3 neighbourhood around (2pr+dy, 2pc+dx); taps outside the image read as 0.
  always_comb begin
    int rr;
    int cc;
    window = '0;
    rr     = 0;
    cc     = 0;
    for (int kr = 0; kr < KSIZE; kr++) begin
      for (int kc = 0; kc < KSIZE; kc++) begin
        rr = 2 * int'(pr) + int'(q[1]) + kr - 1;
        cc = 2 * int'(pc) + int'(q[0]) + kc - 1;
        if (rr >= 0 && rr < IMG_DIM && cc >= 0 && cc < IMG_DIM) begin
          window[4'(kr * KSIZE + kc)] = pixels[10'(pix_idx(rr, cc))];
        end
      end
    end
  end

  always_comb begin
    kern = '{default: '0};
    for (int f = 0; f < L1_FILTERS; f++) begin
      for (int kr = 0; kr < KSIZE; kr++) begin
        for (int kc = 0; kc < KSIZE; kc++) begin
          kern[f][4'(kr * KSIZE + kc)] = weights1[7'(w1_idx(kr, kc, f))];
        end
      end
    end
  end

  for (genvar f = 0; f < L1_FILTERS; f++) begin : g_pe
    bconv3x3_pe #(
      .THRESH(THRESH)
    ) u_pe (
      .window(window),
      .kernel(kern[f]),
      .act   (act[f])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm         <= L1_IDLE;
      fmap1       <= '0;
      layer1_done <= 1'b0;
      pr          <= '0;
      pc          <= '0;
      q           <= '0;
      acc         <= '0;
    end else begin
      unique case (fsm)
        L1_IDLE: begin
          if (state == s_LAYER_1) begin
            fsm   <= L1_RUN;
            fmap1 <= '0;
            pr    <= '0;
            pc    <= '0;
            q     <= '0;
            acc   <= '0;
          end
        end

        L1_RUN: begin
          if (state != s_LAYER_1) begin
            // Abort leaves already-pooled slots in place; a re-entry clears them anyway.
            fsm <= L1_IDLE;
            pr  <= '0;
            pc  <= '0;
            q   <= '0;
            acc <= '0;
          end else begin
            if (q == 2'd0) begin
              acc <= act;
            end else if (q == 2'd3) begin
              fmap1[11'(fm1_idx(int'(pr), int'(pc), 0)) +: L1_FILTERS] <= acc | act;
            end else begin
              acc <= acc | act;
            end

            q <= q + 2'd1;
            if (q == 2'd3) begin
              if (pc == LAST_POS) begin
                pc <= '0;
                if (pr == LAST_POS) begin
                  pr          <= '0;
                  fsm         <= L1_DONE;
                  layer1_done <= 1'b1;
                end else begin
                  pr <= pr + 4'd1;
                end
              end else begin
                pc <= pc + 4'd1;
              end
            end
          end
        end

        L1_DONE: begin
          if (state != s_LAYER_1) begin
            fsm         <= L1_IDLE;
            layer1_done <= 1'b0;
          end
        end

        default: begin
          fsm         <= L1_IDLE;
          layer1_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bnn_layer1_conv.md
# bnn_layer1_conv

Layer-1 compute engine of the binary MNIST network. It consumes the 784-bit binarised image and the 72-bit layer-1 kernel set that the serial loader produces, and evaluates 8 binary 3×3 convolutions with same-padding, a popcount threshold and 2×2 max-pool. The result is a 14×14×8 feature map, laid out channel-innermost, which the layer-2 engine reads directly.

## Interface
Parameters:
- THRESH, 5: minimum XNOR match count (0–9) for an activation bit of 1.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- state  in  3  global phase; engine runs only while state == s_LAYER_1 (3'b010)
- pixels  in  784  image; pixel (r,c) = pixels[r*28+c]; 1 means +1, 0 means −1
- weights1  in  72  kernel bit for filter f, row kr, col kc = weights1[kr*24 + kc*8 + f]
- fmap1  out  1568  pooled output; bit for (pr,pc,f) = fmap1[(pr*14+pc)*8 + f]
- layer1_done  out  1  level; high while the full fmap1 is valid for this pass

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN when state == s_LAYER_1 is sampled. On that edge: fmap1 cleared, counters pr=pc=q=0, acc=0.
- RUN: one conv position per cycle, with all 8 filters evaluated in parallel.
  - Quadrant q: dy=q[1], dx=q[0]. Conv centre is r=2pr+dy, c=2pc+dx.
  - Tap (kr,kc) reads pixel (r+kr−1, c+kc−1). Out-of-bounds reads as 0; it is matched against the weight like any other pixel.
  - Per filter: matches = popcount of 9 XNORs (4-bit, range 0–9); act[f] = (matches ≥ THRESH).
  - q=0: acc ← act. q=1,2: acc ← acc | act. q=3: fmap1 slot (pr,pc) ← acc | act.
  - Counter order: q increments fastest, then pc (0..13), then pr (0..13). All counters wrap to 0.
- RUN → DONE on the edge that processes pr=13, pc=13, q=3. layer1_done ← 1 on that same edge.
- DONE: fmap1 and layer1_done hold while state == s_LAYER_1.
  - Any other state value → IDLE, layer1_done ← 0. fmap1 is retained.
- Abort: state ≠ s_LAYER_1 during RUN → IDLE on the next edge.
  - Counters are cleared. fmap1 keeps any partially written slots. layer1_done stays 0.
- Re-entry to s_LAYER_1 from IDLE always restarts a full pass, clearing fmap1 first.
- Inputs pixels and weights1 must be stable during RUN. They are not latched.

## Timing
- Reset (reset_n=0 at an edge): FSM=IDLE, fmap1=0, layer1_done=0, pr=pc=q=0, acc=0. Reset has priority over every other event, including mid-RUN.
- Edge E0 (state first sampled as s_LAYER_1): IDLE→RUN.
- Edges E1..E784 each process one (pr,pc,q).
  - Pooled slot k (k = pr*14+pc) is written at edge E(4k+4).
  - The last slot is written at E784. layer1_done is visible high after E784.
- Throughput: 784 cycles per image. There is no backpressure.
- Window, popcount and threshold are combinational within one cycle. Only acc, the counters, fmap1 and the FSM are registered.

## Structure
- bnn_pkg (shared):
  - State localparams s_IDLE..s_LAYER_3.
  - IMG_DIM=28, POOL_DIM=14, L1_FILTERS=8, KSIZE=3.
  - Index functions pix_idx(r,c), w1_idx(kr,kc,f) and fm1_idx(pr,pc,f).
  - The registers loader imports the same package.
- Sub-module bconv3x3_pe: inputs are a 9-bit window and a 9-bit kernel, output is the act bit (XNOR, popcount, ≥ THRESH). It is instantiated 8×.
- The top level holds the FSM, counters, padded window gather, acc and the fmap1 write.

## Test plan
- pixels=0, weights1=0, THRESH=5 → every tap matches (9 ≥ 5). All 1568 fmap1 bits = 1; layer1_done rises after E784.
- pixels all 1, weights1=0 → interior matches 0, top-left corner conv has 5 padded matches → 1. fmap1 = 1 for all f at slots (0,0), (0,13), (13,0) and (13,13); every other bit is 0.
- pixels all 1, only filter 3 kernel all 1 → filter 3 bits are all 1; filters 0–2 and 4–7 bits are 1 only at the four corner slots.
- state leaves s_LAYER_1 at cycle 100 of RUN, then returns → layer1_done stays 0. The second pass restarts with fmap1 cleared and completes 784 cycles later with correct data.
- reset_n=0 for 1 cycle at cycle 400 of RUN → fmap1=0, layer1_done=0, FSM=IDLE. With state still s_LAYER_1, a new pass starts on the next edge.
- After DONE, state → s_IDLE → layer1_done drops on the next edge; fmap1 is unchanged.
